// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: light-code bus from the intersection controller, plus the raw walk request
interface traffic_light_monitor_if;
    logic [1:0] ml;
    logic [1:0] sl;
    logic       wl;
    logic       req;
    modport master (output ml, sl, wl, req);
    modport slave  (input ml, sl, wl, req);
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker decoding the light phase and flagging illegal codes,
// sequencing, dwell and walk-request handling errors on the controller's light bus
module traffic_light_monitor #(
    parameter logic [7:0] MG_MIN   = 8'd9,
    parameter logic [7:0] MG_MAX   = 8'd12,
    parameter logic [7:0] SG_MIN   = 8'd6,
    parameter logic [7:0] SG_MAX   = 8'd9,
    parameter logic [7:0] YEL_CYC  = 8'd2,
    parameter logic [7:0] WALK_CYC = 8'd3
) (
    input  logic                          clk,
    input  logic                          reset,
    traffic_light_monitor_if.slave        bus,
    output logic [2:0]                    phase_o,
    output logic [7:0]                    dwell_o,
    output logic                          err_valid_o,
    output logic [2:0]                    err_code_o,
    output logic                          err_sticky_o,
    output logic [7:0]                    err_count_o,
    output logic [7:0]                    walk_count_o
);
    typedef enum logic [2:0] {NONE = 3'd0, MG = 3'd1, MY = 3'd2, SG = 3'd3, SY = 3'd4, WALK = 3'd5} phase_t;
    phase_t     phase_q, phase_d, p;
    logic [4:0] code_in;
    logic [7:0] dwell_q, dwell_d, dwell_inc, min_cur, max_cur;
    logic [7:0] err_count_q, err_count_d, walk_count_q, walk_count_d;
    logic [2:0] err_code_q, err_code_d;
    logic       err_valid_q, err_valid_d, err_sticky_q, err_sticky_d;
    logic       pend_q, pend_d, req_q, req_edge;
    logic       stay, moved, legal, enter_walk;
    logic       e1, e2, e3, e4, e5, e6;
    always_comb begin
        code_in      = {bus.ml, bus.sl, bus.wl};
        p            = code_in == 5'b00100 ? MG :
                       code_in == 5'b01100 ? MY :
                       code_in == 5'b10000 ? SG :
                       code_in == 5'b10010 ? SY :
                       code_in == 5'b10101 ? WALK : NONE;
        min_cur      = phase_q == MG ? MG_MIN : phase_q == SG ? SG_MIN : phase_q == WALK ? WALK_CYC : YEL_CYC;
        max_cur      = phase_q == MG ? MG_MAX : phase_q == SG ? SG_MAX : phase_q == WALK ? WALK_CYC : YEL_CYC;
        // SG->SY is the normal side-yellow step and is accepted alongside the listed edges
        legal        = (phase_q == MG && p == MY) || (phase_q == MY && (p == SG || p == WALK)) ||
                       (phase_q == WALK && p == SG) || (phase_q == SG && p == SY) || (phase_q == SY && p == MG);
        stay         = p != NONE && p == phase_q;
        moved        = p != NONE && phase_q != NONE && p != phase_q;
        enter_walk   = p == WALK && phase_q != WALK;
        req_edge     = bus.req & ~req_q;
        dwell_inc    = dwell_q == 8'hff ? dwell_q : dwell_q + 8'd1;
        e1           = p == NONE;
        e2           = moved && !legal;
        e3           = moved && dwell_q < min_cur;
        e4           = stay && dwell_inc == 8'(max_cur + 8'd1);
        e5           = moved && enter_walk && !pend_q && !req_edge;
        e6           = moved && phase_q == MY && p == SG && pend_q;
        phase_d      = p;
        dwell_d      = e1 ? 8'd0 : stay ? dwell_inc : 8'd1;
        err_valid_d  = e1 | e2 | e3 | e4 | e5 | e6;
        err_code_d   = e1 ? 3'd1 : e2 ? 3'd2 : e3 ? 3'd3 : e4 ? 3'd4 : e5 ? 3'd5 : e6 ? 3'd6 : err_code_q;
        err_sticky_d = err_sticky_q | err_valid_d;
        err_count_d  = err_count_q + 8'(err_valid_d && err_count_q != 8'hff);
        walk_count_d = walk_count_q + 8'(enter_walk);
        pend_d       = enter_walk ? 1'b0 : pend_q | req_edge;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= NONE;
            dwell_q      <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= '0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            walk_count_q <= '0;
            pend_q       <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            dwell_q      <= dwell_d;
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            walk_count_q <= walk_count_d;
            pend_q       <= pend_d;
            req_q        <= bus.req;
        end
    end
    assign phase_o      = phase_q;
    assign dwell_o      = dwell_q;
    assign err_valid_o  = err_valid_q;
    assign err_code_o   = err_code_q;
    assign err_sticky_o = err_sticky_q;
    assign err_count_o  = err_count_q;
    assign walk_count_o = walk_count_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed scenarios plus randomized phase sequences checked against a table-driven model
module tb_traffic_light_monitor;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] phase_o, err_code_o;
    logic [7:0] dwell_o, err_count_o, walk_count_o;
    logic       err_valid_o, err_sticky_o;
    traffic_light_monitor_if bus();
    traffic_light_monitor dut (
        .clk(clk), .reset(reset), .bus(bus),
        .phase_o(phase_o), .dwell_o(dwell_o), .err_valid_o(err_valid_o), .err_code_o(err_code_o),
        .err_sticky_o(err_sticky_o), .err_count_o(err_count_o), .walk_count_o(walk_count_o)
    );
    always #5 clk = ~clk;
    wire [31:0] dvec = {phase_o, dwell_o, err_valid_o, err_code_o, err_sticky_o, err_count_o, walk_count_o};
    int checks = 0, errors = 0;
    int dec[32];
    int mn[6], mx[6];
    bit legal[6][6];
    logic [4:0] enc[6];
    int m_phase, m_dwell, m_code, m_cnt, m_walk;
    bit m_ev, m_sticky, m_pend, m_reqp;

    function automatic logic [31:0] mvec();
        return {3'(m_phase), 8'(m_dwell), m_ev, 3'(m_code), m_sticky, 8'(m_cnt), 8'(m_walk)};
    endfunction

    task automatic model_step(input logic [4:0] c, input bit rq, input bit r);
        int p;
        int errs[$];
        bit edge_s;
        if (r) begin
            m_phase = 0; m_dwell = 0; m_ev = 0; m_code = 0; m_sticky = 0;
            m_cnt = 0; m_walk = 0; m_pend = 0; m_reqp = 0;
            return;
        end
        edge_s = rq && !m_reqp;
        m_reqp = rq;
        p = dec[c];
        if (p == 0) begin
            errs.push_back(1);
            m_dwell = 0;
        end else if (p == m_phase) begin
            if (m_dwell < 255) m_dwell++;
            if (m_dwell == mx[p] + 1) errs.push_back(4);
        end else begin
            if (m_phase != 0) begin
                if (!legal[m_phase][p]) errs.push_back(2);
                if (m_dwell < mn[m_phase]) errs.push_back(3);
                if (p == 5 && !m_pend && !edge_s) errs.push_back(5);
                if (m_phase == 2 && p == 3 && m_pend) errs.push_back(6);
            end
            m_dwell = 1;
        end
        if (p == 5 && m_phase != 5) begin
            m_pend = 0;
            m_walk = (m_walk + 1) % 256;
        end else m_pend = m_pend | edge_s;
        m_phase = p;
        m_ev = errs.size() != 0;
        if (m_ev) begin
            m_code = errs[0];
            m_sticky = 1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic drive(input logic [4:0] c, input bit rq, input bit r);
        bus.ml = c[4:3]; bus.sl = c[2:1]; bus.wl = c[0]; bus.req = rq; reset = r;
        @(posedge clk);
        #1;
        model_step(c, rq, r);
    endtask

    task automatic run(input int p, input int n, input bit rq);
        repeat (n) drive(enc[p], rq, 1'b0);
    endtask

    task automatic test_reset();
        drive(5'b11111, 1'b1, 1'b1);
        drive(5'b11111, 1'b1, 1'b1);
        checks++;
        if (dvec !== 32'd0) begin errors++; $display("FAIL reset: outputs=%h, want 0", dvec); end
    endtask

    task automatic test_normal_cycle();
        int sp[5] = '{1, 2, 3, 4, 1};
        int sn[5] = '{10, 2, 6, 2, 1};
        drive(5'b0, 1'b0, 1'b1);
        for (int s = 0; s < 5; s++)
            for (int k = 0; k < sn[s]; k++) begin
                run(sp[s], 1, 1'b0);
                checks++;
                if (phase_o !== 3'(sp[s]) || err_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL normal_cycle seg %0d: phase=%0d ev=%b, want phase=%0d ev=0", s, phase_o, err_valid_o, sp[s]);
                end
            end
    endtask

    task automatic test_short_yellow();
        drive(5'b0, 1'b0, 1'b1);
        run(1, 10, 1'b0);
        run(2, 1, 1'b0);
        run(3, 1, 1'b0);
        checks++;
        if ({err_valid_o, err_code_o, err_sticky_o, err_count_o} !== {1'b1, 3'd3, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL short_yellow: ev=%b code=%0d sticky=%b count=%0d, want 1 3 1 1", err_valid_o, err_code_o, err_sticky_o, err_count_o);
        end
    endtask

    task automatic test_illegal_code();
        drive(5'b11100, 1'b0, 1'b0);
        checks++;
        if ({err_valid_o, err_code_o, phase_o} !== {1'b1, 3'd1, 3'd0}) begin
            errors++;
            $display("FAIL illegal_code: ev=%b code=%0d phase=%0d, want 1 1 0", err_valid_o, err_code_o, phase_o);
        end
        run(1, 1, 1'b0);
        checks++;
        if ({err_valid_o, phase_o, dwell_o} !== {1'b0, 3'd1, 8'd1}) begin
            errors++;
            $display("FAIL illegal_recover: ev=%b phase=%0d dwell=%0d, want 0 1 1", err_valid_o, phase_o, dwell_o);
        end
    endtask

    task automatic test_walk_request();
        drive(5'b0, 1'b0, 1'b1);
        run(1, 5, 1'b0); run(1, 1, 1'b1); run(1, 4, 1'b0);
        run(2, 2, 1'b0); run(3, 1, 1'b0);
        checks++;
        if ({err_valid_o, err_code_o} !== {1'b1, 3'd6}) begin
            errors++;
            $display("FAIL missed_walk: ev=%b code=%0d, want 1 6", err_valid_o, err_code_o);
        end
        drive(5'b0, 1'b0, 1'b1);
        run(1, 5, 1'b0); run(1, 1, 1'b1); run(1, 4, 1'b0);
        run(2, 2, 1'b0); run(5, 1, 1'b0);
        checks++;
        if ({err_valid_o, phase_o, walk_count_o} !== {1'b0, 3'd5, 8'd1}) begin
            errors++;
            $display("FAIL served_walk: ev=%b phase=%0d walks=%0d, want 0 5 1", err_valid_o, phase_o, walk_count_o);
        end
    endtask

    task automatic test_long_dwell();
        drive(5'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            run(1, 1, 1'b0);
            checks++;
            if (err_valid_o !== (k == 13) || (k == 13 && err_code_o !== 3'd4)) begin
                errors++;
                $display("FAIL long_dwell cyc %0d: ev=%b code=%0d, want ev=%0d code 4 at 13", k, err_valid_o, err_code_o, k == 13);
            end
        end
        run(3, 1, 1'b0);
        checks++;
        if ({err_valid_o, err_code_o} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL bad_edge: ev=%b code=%0d, want 1 2", err_valid_o, err_code_o);
        end
    endtask

    task automatic test_reset_mid();
        drive(5'b0, 1'b0, 1'b1);
        run(1, 1, 1'b0); run(3, 1, 1'b0); run(1, 10, 1'b0); run(2, 2, 1'b0); run(3, 3, 1'b0);
        drive(enc[3], 1'b0, 1'b1);
        checks++;
        if (dvec !== 32'd0) begin errors++; $display("FAIL reset_mid: outputs=%h, want 0", dvec); end
        run(5, 1, 1'b0);
        checks++;
        if ({err_valid_o, phase_o, walk_count_o} !== {1'b0, 3'd5, 8'd1}) begin
            errors++;
            $display("FAIL walk_first: ev=%b phase=%0d walks=%0d, want 0 5 1", err_valid_o, phase_o, walk_count_o);
        end
        run(5, 2, 1'b0); run(3, 6, 1'b0); run(4, 2, 1'b0); run(1, 10, 1'b0); run(2, 2, 1'b0); run(5, 1, 1'b0);
        checks++;
        if ({err_valid_o, err_code_o, walk_count_o} !== {1'b1, 3'd5, 8'd2}) begin
            errors++;
            $display("FAIL walk_reentry: ev=%b code=%0d walks=%0d, want 1 5 2", err_valid_o, err_code_o, walk_count_o);
        end
    endtask

    task automatic test_random();
        int nxt, dur, cyc;
        cyc = 0;
        drive(5'b0, 1'b0, 1'b1);
        while (cyc < 4000) begin
            if ($urandom_range(0, 99) < 5) begin
                dur = 1;
                drive(5'($urandom), $urandom_range(0, 11) == 0, 1'b0);
            end else begin
                nxt = m_phase == 1 ? 2 : m_phase == 2 ? ($urandom_range(0, 1) ? 3 : 5) : m_phase == 3 ? 4 :
                      m_phase == 4 ? 1 : m_phase == 5 ? 3 : $urandom_range(1, 5);
                if ($urandom_range(0, 9) == 0) nxt = $urandom_range(1, 5);
                dur = $urandom_range(0, 4) == 0 ? $urandom_range(1, mx[nxt] + 2) : $urandom_range(mn[nxt], mx[nxt]);
                drive(enc[nxt], $urandom_range(0, 11) == 0, $urandom_range(0, 499) == 0);
            end
            for (int k = 0; k < dur; k++) begin
                if (k > 0) drive(enc[nxt], $urandom_range(0, 11) == 0, $urandom_range(0, 499) == 0);
                cyc++;
                checks++;
                if (dvec !== mvec()) begin
                    errors++;
                    $display("FAIL random cyc %0d: dut=%h model=%h", cyc, dvec, mvec());
                end
            end
        end
    endtask

    initial begin
        bus.ml = 2'b10; bus.sl = 2'b10; bus.wl = 1'b0; bus.req = 1'b0;
        foreach (dec[i]) dec[i] = 0;
        dec[5'b00100] = 1; dec[5'b01100] = 2; dec[5'b10000] = 3; dec[5'b10010] = 4; dec[5'b10101] = 5;
        enc = '{5'b11111, 5'b00100, 5'b01100, 5'b10000, 5'b10010, 5'b10101};
        mn = '{0, 9, 2, 6, 2, 3};
        mx = '{0, 12, 2, 9, 2, 3};
        legal[1][2] = 1; legal[2][3] = 1; legal[2][5] = 1; legal[5][3] = 1; legal[3][4] = 1; legal[4][1] = 1;
        test_reset();
        test_normal_cycle();
        test_short_yellow();
        test_illegal_code();
        test_walk_request();
        test_long_dwell();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
